// File: rtl/tb_defs.sv
// Shared constants for the result reporter: sync marker,
// UART frame size and controller state encodings.
package tb_defs;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         FRAME_BITS = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Ready rises while the stop bit is in its
// final cycle so a following byte starts with no idle gap.
module uart_tx_byte
    import tb_defs::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_tx;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_last    = (r_bit == 4'(FRAME_BITS - 1));
    assign o_ready   = !r_busy || (w_bit_end && w_last);
    assign w_accept  = i_valid && o_ready;
    assign o_tx      = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            // Start bit goes out now; the stop bit rides in shift[8].
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= {1'b1, i_byte};
            r_tx    <= 1'b0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_tx   <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots the scoreboard counters and sends them as one framed
// packet: SYNC, data MSB-first, event MSB-first, XOR checksum.
module result_uart_tx
    import tb_defs::*;
#(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data_ctr,
    input  logic [WIDTH-1:0] i_event_ctr,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int NB     = WIDTH / 8;
    localparam int NBYTES = 2 * NB + 2;
    localparam int IW     = $clog2(NBYTES + 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_event;
    logic [7:0]       r_csum;

    logic       w_start;
    logic       w_valid;
    logic       w_ready;
    logic [7:0] w_byte;

    // Index 0 is SYNC, so the idle mux already presents it on start.
    always_comb begin
        w_byte = SYNC_BYTE;
        for (int i = 0; i < NB; i++) begin
            if (r_idx == IW'(i + 1))
                w_byte = r_data[(NB-1-i)*8 +: 8];
            if (r_idx == IW'(NB + 1 + i))
                w_byte = r_event[(NB-1-i)*8 +: 8];
        end
        if (r_idx == IW'(NBYTES - 1))
            w_byte = r_csum;
    end

    assign w_start = (r_state == ST_IDLE) && i_start;
    assign w_valid = w_start ||
                     ((r_state == ST_SEND) && (r_idx != IW'(NBYTES)));
    assign o_busy  = (r_state == ST_SEND);
    assign o_done  = (r_state == ST_DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .reset  (reset),
        .i_valid(w_valid),
        .i_byte (w_byte),
        .o_ready(w_ready),
        .o_tx   (o_tx)
    );

    // r_idx names the next byte to hand over; NBYTES means all handed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_event <= '0;
            r_csum  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_SEND;
                        r_idx   <= IW'(1);
                        r_data  <= i_data_ctr;
                        r_event <= i_event_ctr;
                        r_csum  <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_ready) begin
                        if (r_idx == IW'(NBYTES)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            if (r_idx <= IW'(NBYTES - 2))
                                r_csum <= r_csum ^ w_byte;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: decodes every frame cycle by
// cycle against hand-computed bytes and checksums.
module tb_result_uart_tx;

    localparam int W      = 32;
    localparam int CPB    = 4;
    localparam int NB     = 4;
    localparam int NBYTES = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_data_ctr;
    logic [31:0] i_event_ctr;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ev;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    result_uart_tx #(
        .WIDTH       (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_data_ctr (i_data_ctr),
        .i_event_ctr(i_event_ctr),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at the first start-bit cycle; leaves at the o_done cycle.
    task automatic rx_frame(input vec_t v, input string tag,
                            input bit snap);
        logic [7:0] exp [NBYTES];
        logic [9:0] bits;
        int bad_time, bad_busy, bad_done, cyc;
        bad_time = 0;
        bad_busy = 0;
        bad_done = 0;
        exp[0] = 8'hA5;
        for (int i = 0; i < NB; i++) begin
            exp[1+i]    = v.data[(NB-1-i)*8 +: 8];
            exp[1+NB+i] = v.ev[(NB-1-i)*8 +: 8];
        end
        exp[NBYTES-1] = v.csum;
        for (int b = 0; b < NBYTES; b++) begin
            bits = '0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    cyc = b*10*CPB + k*CPB + c;
                    if (c == 0) bits[k] = o_tx;
                    else if (o_tx !== bits[k]) bad_time++;
                    if (o_busy !== 1'b1) bad_busy++;
                    if (o_done !== 1'b0) bad_done++;
                    if (snap && cyc == 3) begin
                        i_data_ctr  = 32'hFFFF_FFFF;
                        i_event_ctr = 32'hFFFF_FFFF;
                    end
                    if (snap && cyc == 98) i_start = 1'b1;
                    if (snap && cyc == 99) i_start = 1'b0;
                    step();
                end
            end
            check($sformatf("%s byte%0d", tag, b), 32'(bits),
                  32'({1'b1, exp[b], 1'b0}));
        end
        check({tag, " bit_timing"}, bad_time, 0);
        check({tag, " busy_in_frame"}, bad_busy, 0);
        check({tag, " no_early_done"}, bad_done, 0);
        check({tag, " done_pulse"}, 32'(o_done), 1);
        check({tag, " busy_end"}, 32'(o_busy), 0);
        check({tag, " tx_end"}, 32'(o_tx), 1);
    endtask

    task automatic run(input vec_t v, input string tag,
                       input bit snap);
        i_data_ctr  = v.data;
        i_event_ctr = v.ev;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        rx_frame(v, tag, snap);
        step();
        check({tag, " done_one_cycle"}, 32'(o_done), 0);
        check({tag, " idle_tx"}, 32'(o_tx), 1);
    endtask

    initial begin
        int bad;
        vecs[0] = '{32'h0000_0010, 32'h0000_0003, 8'h13};
        vecs[1] = '{32'hDEAD_BEEF, 32'h1234_5678, 8'h2A};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 8'h00};
        vecs[3] = '{32'h0102_0304, 32'h8040_2010, 8'hF4};
        vecs[4] = '{32'h00C0_FFEE, 32'h0000_0001, 8'hD0};

        reset       = 1'b1;
        i_start     = 1'b0;
        i_data_ctr  = '0;
        i_event_ctr = '0;
        repeat (3) step();
        check("reset tx", 32'(o_tx), 1);
        check("reset busy", 32'(o_busy), 0);
        check("reset done", 32'(o_done), 0);
        reset = 1'b0;
        step();
        check("post_reset busy", 32'(o_busy), 0);

        for (int i = 0; i < 4; i++)
            run(vecs[i], $sformatf("vec%0d", i), 1'b0);

        run(vecs[4], "snap", 1'b1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0)
                bad++;
            step();
        end
        check("snap no_second_frame", bad, 0);

        i_data_ctr  = vecs[3].data;
        i_event_ctr = vecs[3].ev;
        i_start     = 1'b1;
        step();
        rx_frame(vecs[3], "hold1", 1'b0);
        step();
        check("hold gap done", 32'(o_done), 0);
        check("hold gap busy", 32'(o_busy), 0);
        check("hold gap tx", 32'(o_tx), 1);
        step();
        rx_frame(vecs[3], "hold2", 1'b0);
        i_start = 1'b0;
        step();
        step();
        check("hold stop busy", 32'(o_busy), 0);

        i_data_ctr  = vecs[1].data;
        i_event_ctr = vecs[1].ev;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        repeat (148) step();
        check("pre_reset busy", 32'(o_busy), 1);
        reset = 1'b1;
        step();
        check("midreset tx", 32'(o_tx), 1);
        check("midreset busy", 32'(o_busy), 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (o_done !== 1'b0 || o_tx !== 1'b1) bad++;
            step();
        end
        check("abandoned no_done", bad, 0);
        run(vecs[1], "after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
